// File: rtl/seg_display_ctrl.sv
// Sequential 7-segment field formatter: binary -> BCD by shift-add-3, then commit to a per-field register.
// Define SEG_LZB_EN to blank leading zeros in the normal numeric format.
module seg_display_ctrl #(
    parameter int DATA_W       = 10,
    parameter int FIELD_DIGITS = 4,
    parameter int NUM_FIELDS   = 2,
    parameter int FIELD_SEL_W  = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_valid,
    output logic                                wr_ready,
    input  logic [FIELD_SEL_W-1:0]              wr_field,
    input  logic [DATA_W-1:0]                   wr_value,
    input  logic                                wr_neg,
    input  logic                                wr_err,
    input  logic                                wr_blank,
    output logic                                upd_pulse,
    output logic [NUM_FIELDS*FIELD_DIGITS*7-1:0] seg_out
);
    localparam int CONV_DIGITS = (DATA_W + 2) / 3;
    localparam int BCD_W       = CONV_DIGITS * 4;
    localparam int EXT_DIGITS  = (CONV_DIGITS > FIELD_DIGITS) ? CONV_DIGITS : FIELD_DIGITS;
    localparam int EXT_W       = EXT_DIGITS * 4;
    localparam int FIELD_W     = FIELD_DIGITS * 7;
    localparam int CNT_W       = $clog2(DATA_W + 1);

    localparam logic [6:0] SEG_MINUS = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_R     = 7'b1111010;
    localparam logic [6:0] SEG_O     = 7'b1100010;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

    state_t                   state_reg, state_next;
    logic [CNT_W-1:0]         cnt_reg;
    logic [DATA_W-1:0]        val_reg;
    logic [BCD_W-1:0]         bcd_reg;
    logic [BCD_W-1:0]         bcd_adj;
    logic [EXT_W-1:0]         bcd_ext;
    logic [FIELD_SEL_W-1:0]   field_reg;
    logic                     neg_reg, err_reg, blank_reg;
    logic                     upd_pulse_reg;
    logic                     accept, commit, conv_last, ovf;
    logic [FIELD_W-1:0]       fmt_seg;
    logic [3:0]               nib;
`ifdef SEG_LZB_EN
    logic                     seen;
`endif
    logic [FIELD_W-1:0]       field_seg_reg [NUM_FIELDS];

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_seg = 7'b0000001;
            4'd1:    digit_seg = 7'b1001111;
            4'd2:    digit_seg = 7'b0010010;
            4'd3:    digit_seg = 7'b0000110;
            4'd4:    digit_seg = 7'b1001100;
            4'd5:    digit_seg = 7'b0100100;
            4'd6:    digit_seg = 7'b0100000;
            4'd7:    digit_seg = 7'b0001111;
            4'd8:    digit_seg = 7'b0000000;
            4'd9:    digit_seg = 7'b0001100;
            default: digit_seg = 7'b1111111;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (accept)    state_next = S_CONV;
            S_CONV:   if (conv_last) state_next = S_COMMIT;
            S_COMMIT:                state_next = S_IDLE;
            default:                 state_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        wr_ready  = (state_reg == S_IDLE);
        commit    = (state_reg == S_COMMIT);
        accept    = wr_valid && (state_reg == S_IDLE);
        conv_last = (state_reg == S_CONV) && (cnt_reg == CNT_W'(DATA_W - 1));
    end

    generate
        for (genvar gi = 0; gi < CONV_DIGITS; gi++) begin : g_add3
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (accept) begin
            field_reg <= wr_field;
            val_reg   <= wr_value;
            neg_reg   <= wr_neg;
            err_reg   <= wr_err;
            blank_reg <= wr_blank;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
        end else if (state_reg == S_CONV) begin
            bcd_reg   <= BCD_W'({bcd_adj, val_reg[DATA_W-1]});
            val_reg   <= val_reg << 1;
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

    // Zero-extend so field digits beyond the accumulator read as 0.
    assign bcd_ext = EXT_W'(bcd_reg);
    assign ovf     = |bcd_ext[EXT_W-1 : (FIELD_DIGITS-1)*4];

    always_comb begin
        fmt_seg = '1;
        nib     = '0;
`ifdef SEG_LZB_EN
        seen    = 1'b0;
`endif
        if (blank_reg) begin
            fmt_seg = '1;
        end else if (err_reg || ovf) begin
            fmt_seg[(FIELD_DIGITS-1)*7 +: 7] = SEG_E;
            fmt_seg[(FIELD_DIGITS-2)*7 +: 7] = SEG_R;
            fmt_seg[(FIELD_DIGITS-3)*7 +: 7] = SEG_R;
            fmt_seg[(FIELD_DIGITS-4)*7 +: 7] = SEG_O;
        end else begin
            fmt_seg[(FIELD_DIGITS-1)*7 +: 7] = neg_reg ? SEG_MINUS : SEG_BLANK;
            for (int i = FIELD_DIGITS - 2; i >= 0; i--) begin
                nib = bcd_ext[i*4 +: 4];
`ifdef SEG_LZB_EN
                seen = seen | (nib != 4'd0) | (i == 0);
                fmt_seg[i*7 +: 7] = seen ? digit_seg(nib) : SEG_BLANK;
`else
                fmt_seg[i*7 +: 7] = digit_seg(nib);
`endif
            end
        end
    end

    // Out-of-range field indices match no register, so the commit is a no-op.
    generate
        for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
            always_ff @(posedge clk) begin
                if (!rst_n)
                    field_seg_reg[gi] <= '1;
                else if (commit && (field_reg == FIELD_SEL_W'(gi)))
                    field_seg_reg[gi] <= fmt_seg;
            end
            assign seg_out[gi*FIELD_W +: FIELD_W] = field_seg_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) upd_pulse_reg <= 1'b0;
        else        upd_pulse_reg <= commit;
    end

    assign upd_pulse = upd_pulse_reg;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl (3 fields so an out-of-range index exists).
module tb_seg_display_ctrl;
    localparam int NF = 3;

    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] MIN = 7'b1111110;
    localparam logic [6:0] SE  = 7'b0110000;
    localparam logic [6:0] SR  = 7'b1111010;
    localparam logic [6:0] SO  = 7'b1100010;
    localparam logic [27:0] ERRF = {SE, SR, SR, SO};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_field = '0;
    logic [9:0]  wr_value = '0;
    logic        wr_neg = 1'b0, wr_err = 1'b0, wr_blank = 1'b0;
    logic        upd_pulse;
    logic [NF*28-1:0] seg_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [27:0] model_f [NF];

    typedef struct {
        logic [1:0]  field;
        logic [9:0]  value;
        logic        neg, err, blank;
        logic [27:0] exp;
    } vec_t;
    vec_t tbl [9];

    seg_display_ctrl #(.DATA_W(10), .FIELD_DIGITS(4), .NUM_FIELDS(NF), .FIELD_SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_field(wr_field), .wr_value(wr_value), .wr_neg(wr_neg), .wr_err(wr_err),
        .wr_blank(wr_blank), .upd_pulse(upd_pulse), .seg_out(seg_out)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dseg(input int d);
        case (d)
            0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
            3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
            default: return 7'b0001100;
        endcase
    endfunction

    // Reference: decimal digits by division, not by shift-add-3.
    function automatic logic [27:0] ref_field(input int value, input bit neg, input bit err, input bit blank);
        logic [27:0] r;
        int p;
        bit show;
        r = '1;
        if (blank) return r;
        if (err || value >= 1000) return ERRF;
        r[27:21] = neg ? MIN : BLK;
        p = 1;
        for (int i = 0; i < 3; i++) begin
            show = 1'b1;
`ifdef SEG_LZB_EN
            show = (i == 0) || (value >= p);
`endif
            r[i*7 +: 7] = show ? dseg((value / p) % 10) : BLK;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [NF*28-1:0] model_seg();
        return {model_f[2], model_f[1], model_f[0]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] f, input logic [9:0] v, input logic n, input logic e, input logic b);
        int guard, lat, low;
        guard = 0;
        while (!wr_ready && guard < 100) begin tick(); guard++; end
        check("ready_wait", 128'(wr_ready), 128'(1));
        wr_valid = 1'b1; wr_field = f; wr_value = v; wr_neg = n; wr_err = e; wr_blank = b;
        tick();
        wr_valid = 1'b0;
        lat = 0; low = 0;
        while (!upd_pulse && lat < 50) begin
            if (!wr_ready) low++;
            tick();
            lat++;
        end
        check("upd_latency", 128'(lat), 128'(11));
        check("ready_low_cycles", 128'(low), 128'(11));
        check("ready_at_commit", 128'(wr_ready), 128'(1));
        $display("write field=%0d value=%0d neg=%0b err=%0b blank=%0b latency=%0d seg_out=%h",
                 f, v, n, e, b, lat, seg_out);
    endtask

    initial begin
        int first_pulse, second_pulse, k;
        bit saw;
        logic [1:0]  rf;
        logic [9:0]  rv;
        logic        rn, re, rb;

        tbl[0] = '{2'd0, 10'd7,    1'b0, 1'b0, 1'b0, {BLK, dseg(0), dseg(0), dseg(7)}};
        tbl[1] = '{2'd1, 10'd999,  1'b1, 1'b0, 1'b0, {MIN, dseg(9), dseg(9), dseg(9)}};
        tbl[2] = '{2'd0, 10'd1000, 1'b0, 1'b0, 1'b0, ERRF};
        tbl[3] = '{2'd0, 10'd0,    1'b0, 1'b1, 1'b0, ERRF};
        tbl[4] = '{2'd2, 10'd42,   1'b1, 1'b0, 1'b0, {MIN, dseg(0), dseg(4), dseg(2)}};
        tbl[5] = '{2'd1, 10'd5,    1'b0, 1'b0, 1'b1, {BLK, BLK, BLK, BLK}};
        tbl[6] = '{2'd2, 10'd0,    1'b1, 1'b0, 1'b0, {MIN, dseg(0), dseg(0), dseg(0)}};
        tbl[7] = '{2'd0, 10'd1023, 1'b1, 1'b0, 1'b0, ERRF};
        tbl[8] = '{2'd3, 10'd123,  1'b0, 1'b0, 1'b0, '1};
`ifdef SEG_LZB_EN
        tbl[0].exp = {BLK, BLK, BLK, dseg(7)};
        tbl[4].exp = {MIN, BLK, dseg(4), dseg(2)};
        tbl[6].exp = {MIN, BLK, BLK, dseg(0)};
`endif
        for (int i = 0; i < NF; i++) model_f[i] = '1;

        // Reset state
        repeat (3) tick();
        check("reset_seg", 128'(seg_out), 128'(model_seg()));
        check("reset_ready", 128'(wr_ready), 128'(1));
        check("reset_upd", 128'(upd_pulse), 128'(0));
        rst_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 9; i++) begin
            do_write(tbl[i].field, tbl[i].value, tbl[i].neg, tbl[i].err, tbl[i].blank);
            if (tbl[i].field < 2'(NF)) model_f[tbl[i].field] = tbl[i].exp;
            check($sformatf("table_seg_%0d", i), 128'(seg_out), 128'(model_seg()));
            tick();
            check($sformatf("upd_one_cycle_%0d", i), 128'(upd_pulse), 128'(0));
        end

        // Reset during conversion
        wr_valid = 1'b1; wr_field = 2'd1; wr_value = 10'd55; wr_neg = 1'b0; wr_err = 1'b0; wr_blank = 1'b0;
        tick();
        wr_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NF; i++) model_f[i] = '1;
        check("midreset_seg", 128'(seg_out), 128'(model_seg()));
        check("midreset_ready", 128'(wr_ready), 128'(1));
        saw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (upd_pulse) saw = 1'b1;
            tick();
        end
        check("midreset_no_upd", 128'(saw), 128'(0));
        $display("reset mid-conversion seg_out=%h", seg_out);
        do_write(2'd0, 10'd305, 1'b0, 1'b0, 1'b0);
        model_f[0] = ref_field(305, 1'b0, 1'b0, 1'b0);
        check("post_reset_write", 128'(seg_out), 128'(model_seg()));

        // Back-to-back with wr_valid held, payload switched after first accept
        tick();
        wr_valid = 1'b1; wr_field = 2'd0; wr_value = 10'd321; wr_neg = 1'b0; wr_err = 1'b0; wr_blank = 1'b0;
        tick();
        wr_field = 2'd1; wr_value = 10'd64; wr_neg = 1'b1;
        first_pulse = -1; second_pulse = -1;
        for (k = 1; k < 60 && second_pulse < 0; k++) begin
            tick();
            if (upd_pulse) begin
                if (first_pulse < 0) first_pulse = k;
                else second_pulse = k;
            end
            if (first_pulse >= 0 && k == first_pulse + 1) wr_valid = 1'b0;
        end
        wr_valid = 1'b0;
        check("b2b_first", 128'(first_pulse), 128'(11));
        check("b2b_gap", 128'(second_pulse - first_pulse), 128'(12));
        model_f[0] = ref_field(321, 1'b0, 1'b0, 1'b0);
        model_f[1] = ref_field(64, 1'b1, 1'b0, 1'b0);
        check("b2b_seg", 128'(seg_out), 128'(model_seg()));
        $display("back-to-back pulses at %0d and %0d seg_out=%h", first_pulse, second_pulse, seg_out);
        saw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (upd_pulse) saw = 1'b1;
        end
        check("b2b_no_third", 128'(saw), 128'(0));

        // Randomized writes against the reference model
        for (int i = 0; i < 25; i++) begin
            rf = 2'($urandom_range(0, 3));
            rv = 10'($urandom_range(0, 1023));
            if (($urandom & 1) == 1) rv = 10'($urandom_range(0, 120));
            rn = 1'($urandom_range(0, 1));
            re = ($urandom_range(0, 7) == 0);
            rb = ($urandom_range(0, 7) == 0);
            do_write(rf, rv, rn, re, rb);
            if (rf < 2'(NF)) model_f[rf] = ref_field(int'(rv), rn, re, rb);
            check($sformatf("rand_seg_%0d", i), 128'(seg_out), 128'(model_seg()));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
